lives_controller: RTL and testbench
===================================

// Module: lives_controller
// PURPOSE
//  Owns the player's life count and the post-hit invulnerability window.
//  Consumes one-cycle hit / extra-life / new-game events from game logic and a per-frame tick.
//  Drives the 2-bit lives value for the heart display, plus a blink gate and a game_over flag.
//  Sits between collision detection and the HUD sprite path.
// PARAMETERS
//  MAX_LIVES      3    saturation ceiling for extra_life (1..3; lives port is 2 bits)
//  START_LIVES    3    lives loaded on new_game (1..MAX_LIVES)
//  INVULN_FRAMES  120  frame ticks of invulnerability after a non-fatal hit (>=1, fits 8 bits)
//  BLINK_FRAMES   8    frame ticks per lives_visible half-period while invulnerable (>=1)
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous reset, active-low
//  frame_tick     in   1  one-cycle pulse per video frame
//  new_game       in   1  one-cycle pulse: start a game
//  hit            in   1  one-cycle pulse: player collided
//  extra_life     in   1  one-cycle pulse: bonus life awarded
//  lives          out  2  current life count, 0..MAX_LIVES
//  lives_visible  out  1  HUD heart gate: 0 = hearts blanked during the blink phase
//  invulnerable   out  1  1 while hits are ignored
//  game_over      out  1  1 when no game is running
//  hit_accepted   out  1  one-cycle pulse when a hit decremented lives (sound trigger)
// BEHAVIOUR
//  All outputs are registered and change on the clk edge that samples the causing input.
//   Latency is therefore 1 cycle.
//  Reset values:
//   state=S_OVER, lives=0, game_over=1, invulnerable=0, lives_visible=1, hit_accepted=0.
//   The invulnerability and blink counters are cleared.
//  States:
//   S_OVER: idle.
//    - new_game -> S_PLAY; lives=START_LIVES; game_over=0.
//    - hit and extra_life are ignored.
//   S_PLAY: vulnerable.
//    - Effective hit with resulting lives>0 -> S_INVULN.
//      Invuln counter := INVULN_FRAMES; blink counter := BLINK_FRAMES; lives_visible := 0.
//    - Resulting lives==0 -> S_OVER; game_over=1.
//   S_INVULN:
//    - hit is ignored (no decrement, no hit_accepted).
//    - Each frame_tick decrements the invuln counter. The tick that takes it 1->0 moves to S_PLAY
//      with lives_visible=1.
//    - Each frame_tick also decrements the blink counter. At 1 -> reload BLINK_FRAMES and toggle
//      lives_visible.
//  Lives arithmetic, in S_PLAY and S_INVULN:
//   - next = lives - hit_eff + extra_life.
//   - Saturate at MAX_LIVES; never wraps below 0.
//   - hit_eff = hit & (state==S_PLAY).
//  Simultaneous events:
//   - new_game has top priority in every state. It performs the full S_OVER->S_PLAY load and
//     drops the other pulses that cycle.
//   - hit+extra_life in S_PLAY: lives unchanged, but S_INVULN is still entered and hit_accepted=1.
//   - extra_life with frame_tick in S_INVULN: both take effect.
//  Outside S_INVULN: lives_visible=1 and invulnerable=0.
//  hit_accepted is high exactly 1 cycle per effective hit, including the fatal one.
//  frame_tick in S_OVER / S_PLAY has no effect.
//  Async reset mid-game returns to the reset values immediately; there is no partial state.
// STRUCTURE
//  ice_consts.vh (shared include):
//   - 2-bit state encodings S_OVER=0, S_PLAY=1, S_INVULN=2.
//   - LIVES_W=2.
//   - Default MAX_LIVES.
//  One sub-module: frame_timer.
//   - Parameterised width.
//   - Ports: load, load_val, tick enable, count out, expire pulse.
//   - Instantiated twice: invulnerability and blink.
//  FSM and lives arithmetic stay in lives_controller.
// TESTING  (bench params: START_LIVES=3, MAX_LIVES=3, INVULN_FRAMES=4, BLINK_FRAMES=2)
//  1. Reset, then new_game
//     -> lives=3, game_over=0, invulnerable=0, lives_visible=1 one cycle later.
//  2. hit in S_PLAY
//     -> lives=2, hit_accepted 1 cycle, invulnerable=1, lives_visible=0.
//     Then over 4 frame_ticks: lives_visible toggles after tick 2; S_PLAY and lives_visible=1
//     after tick 4.
//  3. hit during S_INVULN -> lives stays 2, no hit_accepted.
//  4. Three effective hits from 3 lives -> lives=0, game_over=1, state S_OVER.
//     Subsequent hit/extra_life -> no change.
//  5. extra_life at lives=3 -> stays 3.
//     hit+extra_life in the same cycle at lives=2 -> stays 2, invulnerable=1.
//  6. new_game coincident with hit while in S_INVULN at lives=1 -> lives=3, S_PLAY.
//     Async rst_n low mid-S_INVULN -> all reset values immediately.

Source files
------------

// File: rtl/lives_controller_pkg.sv
// Shared constants, state encoding and lives arithmetic for the lives controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lives_controller_pkg;

    localparam int LIVES_W       = 2;
    localparam int DEF_MAX_LIVES = 3;

    typedef enum logic [1:0] {
        S_OVER   = 2'd0,
        S_PLAY   = 2'd1,
        S_INVULN = 2'd2
    } state_t;

    // Apply one optional decrement and one optional increment.
    // The result never goes below zero and is clamped to max_lives.
    function automatic logic [LIVES_W-1:0] sat_lives(
        input logic [LIVES_W-1:0] cur,
        input logic               dec,
        input logic               inc,
        input logic [LIVES_W-1:0] max_lives
    );
        logic [LIVES_W:0] sum;
        sum = {1'b0, cur} + {{LIVES_W{1'b0}}, inc};
        if (dec && (sum != '0)) begin
            sum = sum - 1'b1;
        end
        if (sum > {1'b0, max_lives}) begin
            sum = {1'b0, max_lives};
        end
        return sum[LIVES_W-1:0];
    endfunction

endpackage

// File: rtl/lives_controller_frame_timer.sv
// Loadable down-counter of frame ticks with a one-cycle expire strobe.
// Latency: count updates one cycle after load/tick; expire is combinational on the 1->0 tick.
// Backpressure: none; load wins over tick, and the counter holds at zero.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         expire
);

    // The expire strobe lets the owner act on the same edge the counter reaches zero.
    assign expire = tick && (count == W'(1));

    // Load takes priority; otherwise count ticks down and parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/lives_controller.sv
// Life count, post-hit invulnerability window and HUD heart blink for the player.
// Latency: all outputs registered, one cycle after the causing event pulse.
// Backpressure: none; event pulses are always consumed (or deliberately ignored) the cycle they arrive.
module lives_controller
    import lives_controller_pkg::*;
#(
    parameter int MAX_LIVES     = DEF_MAX_LIVES,
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               new_game,
    input  logic               hit,
    input  logic               extra_life,
    output logic [LIVES_W-1:0] lives,
    output logic               lives_visible,
    output logic               invulnerable,
    output logic               game_over,
    output logic               hit_accepted
);

    localparam int INV_W   = 8;
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    state_t             state;
    logic               hit_eff;
    logic [LIVES_W-1:0] next_lives;
    logic               enter_invuln;
    logic               timer_tick;

    logic               inv_load;
    logic [INV_W-1:0]   inv_load_val;
    logic [INV_W-1:0]   inv_count;
    logic               inv_expire;

    logic               blink_load;
    logic [BLINK_W-1:0] blink_load_val;
    logic [BLINK_W-1:0] blink_count;
    logic               blink_expire;
    logic               unused_blink;

    // Hits only count while vulnerable; new_game swallows every other pulse that cycle.
    assign hit_eff      = hit && (state == S_PLAY);
    assign next_lives   = sat_lives(lives, hit_eff, extra_life, LIVES_W'(MAX_LIVES));
    assign enter_invuln = !new_game && hit_eff && (next_lives != '0);

    // Both timers advance only inside an open invulnerability window.
    assign timer_tick = frame_tick && !new_game && (state == S_INVULN) && (inv_count != '0);

    // new_game clears the window; a surviving hit opens a fresh one.
    assign inv_load     = new_game || enter_invuln;
    assign inv_load_val = enter_invuln ? INV_W'(INVULN_FRAMES) : '0;

    // Blink reloads on each half-period, and is cleared when the window closes or a game starts.
    assign blink_load     = new_game || enter_invuln || blink_expire || inv_expire;
    assign blink_load_val = (enter_invuln || (blink_expire && !inv_expire))
                          ? BLINK_W'(BLINK_FRAMES) : '0;

    assign unused_blink = ^blink_count;

    frame_timer #(.W(INV_W)) u_invuln_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (inv_load),
        .load_val (inv_load_val),
        .tick     (timer_tick),
        .count    (inv_count),
        .expire   (inv_expire)
    );

    frame_timer #(.W(BLINK_W)) u_blink_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (blink_load),
        .load_val (blink_load_val),
        .tick     (timer_tick),
        .count    (blink_count),
        .expire   (blink_expire)
    );

    // Game FSM with registered HUD outputs; new_game overrides whatever state we are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_OVER;
            lives         <= '0;
            game_over     <= 1'b1;
            invulnerable  <= 1'b0;
            lives_visible <= 1'b1;
            hit_accepted  <= 1'b0;
        end else begin
            hit_accepted <= 1'b0;
            if (new_game) begin
                state         <= S_PLAY;
                lives         <= LIVES_W'(START_LIVES);
                game_over     <= 1'b0;
                invulnerable  <= 1'b0;
                lives_visible <= 1'b1;
            end else begin
                case (state)
                    S_PLAY: begin
                        lives <= next_lives;
                        if (hit_eff) begin
                            hit_accepted <= 1'b1;
                            if (next_lives == '0) begin
                                state     <= S_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state         <= S_INVULN;
                                invulnerable  <= 1'b1;
                                lives_visible <= 1'b0;
                            end
                        end
                    end
                    S_INVULN: begin
                        lives <= next_lives;
                        if (inv_expire) begin
                            state         <= S_PLAY;
                            invulnerable  <= 1'b0;
                            lives_visible <= 1'b1;
                        end else if (blink_expire) begin
                            lives_visible <= !lives_visible;
                        end
                    end
                    default: begin
                        // Idle between games: hit, extra_life and frame_tick do nothing.
                        state <= S_OVER;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lives_controller.sv
// Scoreboard bench for lives_controller with short invulnerability/blink windows.
// Latency: expects every output one cycle after the driven pulse.
// Backpressure: n/a; the monitor checks one queued expectation per clock.
module tb_lives_controller;

    typedef struct packed {
        logic [1:0] lives;
        logic       vis;
        logic       inv;
        logic       go;
        logic       ha;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       new_game;
    logic       hit;
    logic       extra_life;
    logic [1:0] lives;
    logic       lives_visible;
    logic       invulnerable;
    logic       game_over;
    logic       hit_accepted;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    lives_controller #(
        .MAX_LIVES     (3),
        .START_LIVES   (3),
        .INVULN_FRAMES (4),
        .BLINK_FRAMES  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .new_game      (new_game),
        .hit           (hit),
        .extra_life    (extra_life),
        .lives         (lives),
        .lives_visible (lives_visible),
        .invulnerable  (invulnerable),
        .game_over     (game_over),
        .hit_accepted  (hit_accepted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = '{lives: lives, vis: lives_visible, inv: invulnerable, go: game_over, ha: hit_accepted};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got lives=%0d vis=%0d inv=%0d go=%0d ha=%0d, want lives=%0d vis=%0d inv=%0d go=%0d ha=%0d",
                     name, a.lives, a.vis, a.inv, a.go, a.ha, e.lives, e.vis, e.inv, e.go, e.ha);
        end
    endtask

    // One cycle of stimulus plus the outputs expected after the next clock edge.
    task automatic step(input string name, input logic ng, input logic h, input logic xl,
                        input logic ft, input logic [1:0] el, input logic ev, input logic ei,
                        input logic eg, input logic eh);
        @(negedge clk);
        new_game   = ng;
        hit        = h;
        extra_life = xl;
        frame_tick = ft;
        exp_q.push_back('{lives: el, vis: ev, inv: ei, go: eg, ha: eh});
        name_q.push_back(name);
    endtask

    // Four frame ticks through a window of INVULN=4, BLINK=2.
    task automatic window(input string tag, input logic [1:0] l);
        step({tag, "_t1"}, 0, 0, 0, 1, l, 0, 1, 0, 0);
        step({tag, "_t2"}, 0, 0, 0, 1, l, 1, 1, 0, 0);
        step({tag, "_t3"}, 0, 0, 0, 1, l, 1, 1, 0, 0);
        step({tag, "_t4"}, 0, 0, 0, 1, l, 1, 0, 0, 0);
    endtask

    // Monitor: compare one expectation per clock, sampled just after the edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, e);
            end
        end
    end

    // Watchdog so a stuck run still terminates with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        new_game   = 1'b0;
        hit        = 1'b0;
        extra_life = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hold", '{lives: 2'd0, vis: 1'b1, inv: 1'b0, go: 1'b1, ha: 1'b0});
        rst_n = 1'b1;

        // Idle: nothing but new_game matters.
        step("idle",      0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("over_tick", 0, 0, 0, 1, 0, 1, 0, 1, 0);
        step("over_hit",  0, 1, 0, 0, 0, 1, 0, 1, 0);
        step("over_xl",   0, 0, 1, 0, 0, 1, 0, 1, 0);

        // Start a game, then vulnerable-state no-ops.
        step("new_game",  1, 0, 0, 0, 3, 1, 0, 0, 0);
        step("ng_hold",   0, 0, 0, 0, 3, 1, 0, 0, 0);
        step("play_tick", 0, 0, 0, 1, 3, 1, 0, 0, 0);
        step("xl_sat",    0, 0, 1, 0, 3, 1, 0, 0, 0);

        // First hit and its window, with an ignored hit and an idle gap inside it.
        step("hit1",      0, 1, 0, 0, 2, 0, 1, 0, 1);
        step("hit1_post", 0, 0, 0, 0, 2, 0, 1, 0, 0);
        step("inv_hit",   0, 1, 0, 0, 2, 0, 1, 0, 0);
        step("w1_t1",     0, 0, 0, 1, 2, 0, 1, 0, 0);
        step("w1_gap",    0, 0, 0, 0, 2, 0, 1, 0, 0);
        step("w1_t2",     0, 0, 0, 1, 2, 1, 1, 0, 0);
        step("w1_t3",     0, 0, 0, 1, 2, 1, 1, 0, 0);
        step("w1_t4",     0, 0, 0, 1, 2, 1, 0, 0, 0);

        // hit + extra_life together: lives unchanged but window opens.
        step("hit_xl",    0, 1, 1, 0, 2, 0, 1, 0, 1);
        // extra_life and frame_tick together inside the window both act.
        step("xl_tick",   0, 0, 1, 1, 3, 0, 1, 0, 0);
        step("w2_t2",     0, 0, 0, 1, 3, 1, 1, 0, 0);
        step("w2_t3",     0, 0, 0, 1, 3, 1, 1, 0, 0);
        step("w2_t4",     0, 0, 0, 1, 3, 1, 0, 0, 0);

        // Three effective hits from three lives end the game.
        step("hitA",      0, 1, 0, 0, 2, 0, 1, 0, 1);
        window("wA", 2);
        step("hitB",      0, 1, 0, 0, 1, 0, 1, 0, 1);
        window("wB", 1);
        step("hitC_fatal",0, 1, 0, 0, 0, 1, 0, 1, 1);
        step("dead_hit",  0, 1, 0, 0, 0, 1, 0, 1, 0);
        step("dead_xl",   0, 0, 1, 0, 0, 1, 0, 1, 0);

        // new_game beats a coincident hit while invulnerable at one life.
        step("ng2",       1, 0, 0, 0, 3, 1, 0, 0, 0);
        step("hitD",      0, 1, 0, 0, 2, 0, 1, 0, 1);
        window("wD", 2);
        step("hitE",      0, 1, 0, 0, 1, 0, 1, 0, 1);
        step("ng_hit",    1, 1, 0, 0, 3, 1, 0, 0, 0);
        step("ng_hit_post",0, 0, 0, 1, 3, 1, 0, 0, 0);

        // Async reset in the middle of a window.
        step("hitF",      0, 1, 0, 0, 2, 0, 1, 0, 1);
        step("wF_t1",     0, 0, 0, 1, 2, 0, 1, 0, 0);
        @(negedge clk);
        frame_tick = 1'b0;
        hit        = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", '{lives: 2'd0, vis: 1'b1, inv: 1'b0, go: 1'b1, ha: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_tick", 0, 0, 0, 1, 0, 1, 0, 1, 0);

        // Fresh game after reset: counters must start clean.
        step("ng3",       1, 0, 0, 0, 3, 1, 0, 0, 0);
        step("hitG",      0, 1, 0, 0, 2, 0, 1, 0, 1);
        window("wG", 2);
        step("end_idle",  0, 0, 0, 0, 2, 1, 0, 0, 0);

        @(negedge clk);
        new_game   = 1'b0;
        hit        = 1'b0;
        extra_life = 1'b0;
        frame_tick = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
